// File: rtl/div_result_uart_tx.sv
// Purpose : serialise a captured divider quotient (and optionally remainder) as big-endian 8N1 UART frames.
// Latency : tx drops to the start bit on the same edge that samples start; frames follow back to back.
// Backpress: none; start is ignored while busy, and there is no queueing.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset, overrides everything
//   start      one-cycle request, only honoured in IDLE
//   result     quotient, captured on an accepted start
//   remainder  remainder, captured on an accepted start (sent only when SEND_REMAINDER != 0)
//   tx         UART line, idles high
//   busy       high for exactly NBYTES*10*CLKS_PER_BIT cycles per transmission
//   done       one-cycle pulse in the first cycle after busy falls
module div_result_uart_tx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int SEND_REMAINDER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] result,
    input  logic [31:0] remainder,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int              BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int              NBYTES    = (SEND_REMAINDER != 0) ? 8 : 4;
    localparam logic [2:0]      BYTE_LAST = 3'(NBYTES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] DATA_BITS = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [63:0]   shift_q,    shift_d;
    logic          tx_q,       tx_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    logic [7:0]    cur_byte;
    logic          baud_tick;

    // The byte being sent always sits in the top of the shift register;
    // it advances by one byte at the end of each stop bit.
    assign cur_byte  = shift_q[63:56];
    assign baud_tick = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START_BIT;
                    shift_d    = (SEND_REMAINDER != 0) ? {result, remainder} : {result, 32'h0};
                    baud_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START_BIT: begin
                if (baud_tick) begin
                    state_d    = DATA_BITS;
                    baud_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    tx_d       = cur_byte[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            DATA_BITS: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = STOP_BIT;
                        bit_cnt_d = 3'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = cur_byte[bit_cnt_q + 3'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            STOP_BIT: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d    = IDLE;
                        byte_cnt_d = 3'd0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        // Next frame starts immediately: no idle gap between bytes.
                        state_d    = START_BIT;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        shift_d    = {shift_q[55:0], 8'h00};
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 3'd0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            shift_q    <= 64'h0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_div_result_uart_tx.sv
// Purpose : self-checking bench for div_result_uart_tx with CLKS_PER_BIT=4, both byte-count variants.
// Latency : each check runs on the falling edge, one cycle per serial sample.
// Backpress: n/a.
module tb_div_result_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start4;
    logic [31:0] result, remainder;
    logic        tx8, busy8, done8;
    logic        tx4, busy4, done4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_result_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_REMAINDER(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .result(result), .remainder(remainder),
        .tx(tx8), .busy(busy8), .done(done8)
    );

    div_result_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_REMAINDER(0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .result(result), .remainder(remainder),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    typedef struct {
        bit          wide;       // 1: 8-byte instance, 0: 4-byte instance
        logic [31:0] res;
        logic [31:0] rem;
        logic [63:0] exp_bytes;  // expected byte stream, first byte in [63:56]
        int          busy_len;   // expected busy cycles
        bit          chained;    // started by the previous entry's done-cycle start
        bit          restart;    // assert start on this entry's done cycle
        bit          disturb;    // pulse start and change result mid-flight
        bit          abort_first;// run and reset a transmission in byte 3 first
    } vec_t;

    vec_t vecs[5];

    function automatic logic [2:0] obs(input bit wide);
        return wide ? {tx8, busy8, done8} : {tx4, busy4, done4};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: tx/busy/done got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_start(input bit wide, input logic v);
        if (wide) start8 = v;
        else      start4 = v;
    endtask

    // Called at the falling edge just after the edge that accepted start.
    task automatic check_frame(input bit wide, input logic [63:0] exp_bytes,
                               input int busy_len, input bit restart, input string tag);
        int   nbytes;
        int   bitpos;
        int   byte_idx;
        logic [7:0] b;
        logic exp_tx;
        nbytes = busy_len / (10 * CPB);
        for (int k = 0; k < busy_len; k++) begin
            bitpos   = (k / CPB) % 10;
            byte_idx = k / (10 * CPB);
            b        = exp_bytes[63 - 8*byte_idx -: 8];
            if (bitpos == 0)      exp_tx = 1'b0;
            else if (bitpos == 9) exp_tx = 1'b1;
            else                  exp_tx = b[bitpos-1];
            check($sformatf("%s cyc%0d", tag, k), obs(wide), {exp_tx, 1'b1, 1'b0});
            @(negedge clk);
        end
        check($sformatf("%s done_cycle (nbytes=%0d)", tag, nbytes), obs(wide), 3'b101);
        if (restart) begin
            set_start(wide, 1'b1);
            @(negedge clk);
            set_start(wide, 1'b0);
        end else begin
            @(negedge clk);
            check($sformatf("%s after_done", tag), obs(wide), 3'b100);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        wide res           rem           exp_bytes               len  ch rs ds ab
        vecs[0] = '{1'b1, 32'h0000_0007, 32'h0000_0001, 64'h00000007_00000001, 320, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0007, 32'h0000_0001, 64'h00000007_00000001, 320, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'hA5C3_0F81, 32'h1234_5678, 64'hA5C30F81_00000000, 160, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h8001_7E3C, 32'h0000_0000, 64'h80017E3C_00000000, 160, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'hDEAD_BEEF, 32'h0F1E_2D3C, 64'hDEADBEEF_0F1E2D3C, 320, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        result = 32'h0; remainder = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: line high, not busy, no done.
        for (int i = 0; i < 10; i++) begin
            check($sformatf("reset_idle8 cyc%0d", i), obs(1'b1), 3'b100);
            check($sformatf("reset_idle4 cyc%0d", i), obs(1'b0), 3'b100);
            @(negedge clk);
        end

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].abort_first) begin
                // Reset lands in the third byte's data bits (cycles 84..115 of the frame).
                result = 32'hFFFF_0000;
                set_start(vecs[v].wide, 1'b1);
                @(negedge clk);
                set_start(vecs[v].wide, 1'b0);
                repeat (90) @(negedge clk);
                check("abort pre_reset busy", obs(vecs[v].wide) & 3'b011, 3'b010);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort reset_edge", obs(vecs[v].wide), 3'b100);
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    check($sformatf("abort no_done cyc%0d", i), obs(vecs[v].wide), 3'b100);
                end
            end

            if (!vecs[v].chained) begin
                result    = vecs[v].res;
                remainder = vecs[v].rem;
                set_start(vecs[v].wide, 1'b1);
                @(negedge clk);
                set_start(vecs[v].wide, 1'b0);
            end

            if (vecs[v].disturb) begin
                fork
                    check_frame(vecs[v].wide, vecs[v].exp_bytes, vecs[v].busy_len,
                                vecs[v].restart, $sformatf("vec%0d", v));
                    begin
                        repeat (50) @(negedge clk);
                        set_start(vecs[v].wide, 1'b1);
                        result = 32'hFFFF_FFFF;
                        @(negedge clk);
                        set_start(vecs[v].wide, 1'b0);
                    end
                join
                // The ignored start must not have queued a second transmission.
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check($sformatf("vec%0d ignored_start cyc%0d", v, i), obs(vecs[v].wide), 3'b100);
                end
            end else begin
                check_frame(vecs[v].wide, vecs[v].exp_bytes, vecs[v].busy_len,
                            vecs[v].restart, $sformatf("vec%0d", v));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
